// File: rtl/rv32v_completion_tracker.sv
`default_nettype none
// ============================================================================
// Module   : rv32v_completion_tracker
// Purpose  : Counts completed elements of the active RV32V op and flags
//            completion (next_v_done / v_done) and op-in-flight (v_busy).
//            Optional macro RV32V_EXC_ELEMENT_EN adds element-exception capture.
// Revision : 1.0 - initial release
// ============================================================================
module rv32v_completion_tracker #(
    parameter  int NUM_LANES = 2,
    parameter  int VLMAX     = 32,
    localparam int VL_W      = $clog2(VLMAX + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      flush,
    input  logic                      start,
    input  logic [VL_W-1:0]           vl,
    input  logic [NUM_LANES-1:0]      wb_valid,
`ifdef RV32V_EXC_ELEMENT_EN
    input  logic [NUM_LANES-1:0]      exc_valid,
    input  logic [NUM_LANES*VL_W-1:0] exc_idx,
`endif
    output logic                      v_busy,
    output logic                      next_v_done,
    output logic                      v_done,
    output logic [VL_W-1:0]           elem_count,
    output logic                      exception_v,
    output logic [VL_W-1:0]           exc_elem
);

    localparam logic [1:0]      c_ST_IDLE   = 2'd0;
    localparam logic [1:0]      c_ST_ACTIVE = 2'd1;
    localparam logic [1:0]      c_ST_DONE   = 2'd2;
    localparam logic [VL_W-1:0] c_VLMAX     = VL_W'(VLMAX);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [VL_W-1:0] r_vl_q;
    logic [VL_W-1:0] r_count;
    logic            r_v_done;
    logic [VL_W:0]   w_inc;
    logic [VL_W:0]   w_sum;
    logic [VL_W-1:0] w_sum_sat;
    logic [VL_W-1:0] w_vl_clamp;
    logic            w_start_ok;
    logic            w_count_hit;
    logic            w_exc_hit;

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_inc = w_inc + {{VL_W{1'b0}}, wb_valid[i]};
        end
    end

    assign w_sum       = {1'b0, r_count} + w_inc;
    assign w_count_hit = (w_sum >= {1'b0, r_vl_q});
    assign w_sum_sat   = w_count_hit ? r_vl_q : w_sum[VL_W-1:0];
    assign w_vl_clamp  = (vl > c_VLMAX) ? c_VLMAX : vl;
    // A start while ACTIVE is ignored, and flush drops a coincident start.
    assign w_start_ok  = start & ~flush & (r_state != c_ST_ACTIVE);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_ACTIVE: begin
                    if (w_count_hit || w_exc_hit) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        w_state_nxt = (vl != '0) ? c_ST_ACTIVE : c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Outputs: entering DONE is exactly a completion event.
    always_comb begin
        next_v_done = ~RST & (w_state_nxt == c_ST_DONE);
        v_busy      = (r_state == c_ST_ACTIVE);
        v_done      = r_v_done;
        elem_count  = r_count;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vl_q   <= '0;
            r_count  <= '0;
            r_v_done <= 1'b0;
        end else begin
            r_v_done <= next_v_done;
            if (flush || w_start_ok) begin
                r_count <= '0;
            end else if (r_state == c_ST_ACTIVE) begin
                r_count <= w_sum_sat;
            end
            if (w_start_ok) begin
                r_vl_q <= w_vl_clamp;
            end
        end
    end

`ifdef RV32V_EXC_ELEMENT_EN
    logic            r_exc_v;
    logic [VL_W-1:0] r_exc_elem;
    logic [VL_W-1:0] w_exc_min;

    always_comb begin
        w_exc_min = '1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (exc_valid[i] && (exc_idx[i*VL_W +: VL_W] < w_exc_min)) begin
                w_exc_min = exc_idx[i*VL_W +: VL_W];
            end
        end
    end

    assign w_exc_hit = (r_state == c_ST_ACTIVE) & (|exc_valid);

    // Only the first exception cycle of an op is captured.
    always_ff @(posedge CLK) begin
        if (RST || flush || w_start_ok) begin
            r_exc_v    <= 1'b0;
            r_exc_elem <= '0;
        end else if (w_exc_hit && !r_exc_v) begin
            r_exc_v    <= 1'b1;
            r_exc_elem <= w_exc_min;
        end
    end

    assign exception_v = r_exc_v;
    assign exc_elem    = r_exc_elem;
`else
    assign w_exc_hit   = 1'b0;
    assign exception_v = 1'b0;
    assign exc_elem    = '0;
`endif

endmodule
`default_nettype wire
